// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port (CPU "C", debug/DMA "D") arbiter and access
// sequencer for a shared single-port data memory. It generates the word
// address, byte enables and lane-replicated store data from the offset and
// size of each access, and returns the load data right-aligned and
// zero-extended. Misaligned or illegal accesses finish in one cycle with err
// set and do not touch memory.
//
// Optional feature: define DM_ARB_RR_EN for round-robin arbitration.
// Without it, C always beats D and the pointer register is not built.
module dm_port_arbiter #(
    parameter int unsigned MEM_LAT = 1  // memory cycles per access, 1..15
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    // port C (CPU MEM stage)
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [2:0]  c_size,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_done,
    output logic        c_err,
    output logic        c_stall,
    // port D (debug / DMA)
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    // memory side
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Access sizes as encoded on the size inputs.
    localparam logic [2:0] SZ_WORD = 3'd0;
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;

    // The counter starts at MEM_LAT-1 and the access ends when it reaches 0.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    // Grant encoding: 0 = port C, 1 = port D.
    localparam logic GNT_C = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_e      state_q, state_d;
    logic        gnt_q,   gnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  size_q,  size_d;
    logic [3:0]  be_q,    be_d;
    logic [31:0] wd_q,    wd_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q,   err_d;

    logic        any_req;
    logic        win;        // requester chosen this cycle if in IDLE
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [2:0]  sel_size;
    logic [31:0] sel_wdata;
    logic        sel_illegal;
    logic        done;

    // ------------------------------------------------------------------
    // Access decode helpers
    // ------------------------------------------------------------------
    function automatic logic acc_illegal(input logic [2:0] size, input logic [1:0] off);
        case (size)
            SZ_WORD: acc_illegal = (off != 2'b00);
            SZ_BYTE: acc_illegal = 1'b0;
            SZ_HALF: acc_illegal = off[0];
            default: acc_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            SZ_WORD: byte_en = 4'b1111;
            SZ_BYTE: byte_en = 4'b0001 << off;
            SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] size, input logic [31:0] wdata);
        case (size)
            SZ_WORD: lane_wdata = wdata;
            SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
            SZ_HALF: lane_wdata = {2{wdata[15:0]}};
            default: lane_wdata = '0;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: load_data = {24'b0, shifted[7:0]};
            SZ_HALF: load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    endfunction

    assign any_req = c_req | d_req;

`ifdef DM_ARB_RR_EN
    logic last_q, last_d;  // last granted port; reset to D so C wins first

    // Round-robin: on contention the port not granted last time wins.
    assign win = (c_req & d_req) ? ~last_q : d_req;

    // Pointer follows every grant made in IDLE.
    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && any_req) begin
            last_d = win;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= GNT_D;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: D is granted only when C is not requesting.
    assign win = c_req ? GNT_C : GNT_D;
`endif

    // Select the winning requester's access attributes.
    always_comb begin
        sel_we      = (win == GNT_D) ? d_we    : c_we;
        sel_addr    = (win == GNT_D) ? d_addr  : c_addr;
        sel_size    = (win == GNT_D) ? d_size  : c_size;
        sel_wdata   = (win == GNT_D) ? d_wdata : c_wdata;
        sel_illegal = acc_illegal(sel_size, sel_addr[1:0]);
    end

    // State and latched-access registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_C;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: every register here updates with <= so all of them see the
            // values from before this edge, independent of statement order.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next state: latch the winner in IDLE, count down in ACCESS, then DONE.
    always_comb begin
        // NOTE: defaulting every _d to its _q first keeps this block free of
        // inferred latches on paths that do not assign a value.
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        be_d    = be_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = win;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    size_d  = sel_size;
                    be_d    = byte_en(sel_size, sel_addr[1:0]);
                    wd_d    = lane_wdata(sel_size, sel_wdata);
                    err_d   = sel_illegal;
                    rdata_d = '0;
                    cnt_d   = CNT_INIT;
                    state_d = sel_illegal ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Stores return zero read data.
                    rdata_d = we_q ? 32'd0 : load_data(size_q, addr_q[1:0], m_rdata);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: memory strobes only in ACCESS, done/err only on the granted port.
    always_comb begin
        m_en    = (state_q == ST_ACCESS);
        m_we    = m_en & we_q;
        m_addr  = m_en ? {addr_q[31:2], 2'b00} : 32'd0;
        m_be    = m_en ? be_q : 4'b0000;
        m_wdata = m_en ? wd_q : 32'd0;
        done    = (state_q == ST_DONE);
        c_done  = done & (gnt_q == GNT_C);
        d_done  = done & (gnt_q == GNT_D);
        c_err   = c_done & err_q;
        d_err   = d_done & err_q;
        c_rdata = rdata_q;
        d_rdata = rdata_q;
        c_stall = c_req & ~c_done;
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Sequencer and arbiter for the shared single-port data memory. It accepts load/store requests from two requesters: port C, the CPU MEM stage, and port D, a debug/DMA master. It grants one requester at a time and generates word address, byte enables and lane-replicated write data from address offset and access size. It returns lane-aligned read data, a one-cycle done pulse, a combinational stall for the CPU pipeline, and flags misaligned accesses without touching memory.

## Interface
Parameters:
- MEM_LAT, 1: memory access cycles per request; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  CPU request; held high until c_done.
- c_we  in  1  CPU store (1) / load (0).
- c_addr  in  32  CPU byte address.
- c_size  in  3  access size: 0 word, 1 byte, 2 halfword; 3..7 illegal.
- c_wdata  in  32  CPU store data, right-aligned.
- c_rdata  out  32  load data, right-aligned, zero-extended.
- c_done  out  1  one-cycle completion pulse.
- c_err  out  1  misaligned/illegal flag, valid with c_done.
- c_stall  out  1  c_req & ~c_done, combinational.
- d_req, d_we, d_addr, d_size, d_wdata, d_rdata, d_done, d_err: port D, identical semantics (no stall output).
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  32  {addr[31:2],2'b00}.
- m_be  out  4  byte enables.
- m_wdata  out  32  lane-replicated write data.
- m_rdata  in  32  memory read word, valid in last access cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, pick a winner, latch its we/addr/size/wdata and the grant ID.
  - If the latched access is legal, go to ACCESS with counter = MEM_LAT-1.
  - If it is illegal, go directly to DONE with err set.
- ACCESS: m_en=1, m_we=latched we, address/be/wdata driven from latched values. The counter decrements each cycle. When the counter is 0, capture m_rdata into the read register and go to DONE.
- DONE: done=1 and err on the granted port only. Rdata is valid on both rdata outputs and is meaningful for the granted port. Next state is always IDLE; no arbitration happens in DONE.
- Byte enables:
  - size 2: offset 0 → 0011, offset 2 → 1100.
  - size 1: offsets 0..3 → 0001, 0010, 0100, 1000.
  - size 0: 1111.
- Illegal accesses: size 2 with addr[0]=1; size 0 with addr[1:0]≠0; size ≥3.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word unchanged.
- Read data: m_rdata shifted right by 8×offset, then masked to 8/16/32 bits. Loads only; stores return 0.
- A requester must deassert req the cycle after done. If req is still high in IDLE, it is treated as a new request.

## Timing
- Reset (asynchronous, active-low): state IDLE; m_en, m_we, m_be, m_addr, m_wdata, c_/d_rdata, c_/d_done, c_/d_err all 0; RR pointer = D, so C wins first.
- Legal access: req sampled in IDLE at cycle 0 → ACCESS cycles 1..MEM_LAT → done in cycle MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Illegal access: done and err in cycle 1; m_en stays 0 throughout.
- Memory outputs are registered in ACCESS and are 0 outside ACCESS.
- Simultaneous requests in IDLE are resolved per Configuration. The losing requester stalls until its own done.
- Request changes during ACCESS/DONE are ignored; the latched values are used.
- Reset asserted mid-access abandons the access: no done pulse, outputs 0 immediately.

## Configuration
- DM_ARB_RR_EN defined: round-robin. The winner is the port not granted last time; the pointer updates on each grant.
- DM_ARB_RR_EN undefined: fixed priority, C always beats D. The pointer register is not present.

## Test plan
- MEM_LAT=2, C store size 1, addr 0x00000013, wdata 0x000000AB → m_en cycles 1-2, m_addr 0x00000010, m_be 1000, m_wdata 0xABABABAB; c_done in cycle 3, c_err 0.
- C load size 2, addr 0x22, m_rdata 0xBEEF1234 → m_be 1100, c_rdata 0x0000BEEF with c_done.
- C load size 0, addr 0x06 → c_done and c_err in cycle 1, m_en never 1, c_stall high in cycle 0 only.
- C and D request simultaneously for three consecutive transactions:
  - with DM_ARB_RR_EN, grants are C, D, C;
  - without it, C wins every cycle it requests and D completes only once C drops.
- Reset driven low in cycle 1 of ACCESS → all outputs 0 asynchronously, no done. After release, a new C request completes normally with latency MEM_LAT+1.
